// File: rtl/game_control_hub_pkg.sv
// Shared types and constants for the game control hub: controller states,
// LED field layout and counter sizing.
package game_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    IDLE  = 2'd1,
    PLAY  = 2'd2,
    PAUSE = 2'd3
  } ctl_state_t;

  localparam int MAX_PLAYERS   = 8;
  localparam int LED_W         = 10;
  localparam int LED_Z_LSB     = 0;
  localparam int LED_STATE_LSB = 8;
  localparam int LED_STATE_MSB = 9;

  // Width for a counter holding 0..limit-1; never narrower than one bit.
  function automatic int cnt_w(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/game_control_hub_if.sv
// Bundle of the hub's button inputs and status outputs. There is no valid/ready
// handshake: press and start outputs are one-cycle strobes that must be sampled every cycle.
interface game_control_hub_if
  import game_pkg::*;
#(
  parameter int NUM_PLAYERS = 2
);
  logic [NUM_PLAYERS-1:0] z_btn;
  logic [NUM_PLAYERS-1:0] c_btn;
  logic                   frame_tick;
  logic [NUM_PLAYERS-1:0] z_press;
  logic [NUM_PLAYERS-1:0] c_press;
  logic                   game_rst;
  logic                   game_run;
  logic                   start_pulse;
  logic [1:0]             state;
  logic [2:0]             paused_by;
  logic [LED_W-1:0]       leds;

  modport master (
    output z_btn, c_btn, frame_tick,
    input  z_press, c_press, game_rst, game_run, start_pulse, state, paused_by, leds
  );

  modport slave (
    input  z_btn, c_btn, frame_tick,
    output z_press, c_press, game_rst, game_run, start_pulse, state, paused_by, leds
  );
endinterface

// File: rtl/button_debounce.sv
// One raw button: 2-flop synchronizer, stable-count debouncer and rising-edge
// detector. rise_o leads press_o by one cycle so the FSM can register on it.
module button_debounce
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw_i,
  output logic level_o,
  output logic rise_o,
  output logic press_o
);
  localparam int            CW       = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          level_q, level_d;
  logic          prev_q, press_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // The count only runs while the synchronized value disagrees with the level,
  // so any return to the old value restarts it from zero.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (s2_q != level_q) begin
      if (cnt_q == CNT_LAST) level_d = ~level_q;
      else                   cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      s1_q    <= btn_raw_i;
      s2_q    <= s1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      prev_q  <= level_q;
      press_q <= rise_o;
    end
  end

  assign level_o = level_q;
  assign rise_o  = level_q & ~prev_q;
  assign press_o = press_q;
endmodule

// File: rtl/game_control_hub.sv
// Controller front end: debounces every player's Z/C buttons and runs the
// HOLD/IDLE/PLAY/PAUSE game-control state machine with chord soft reset.
module game_control_hub
  import game_pkg::*;
#(
  parameter int NUM_PLAYERS     = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int RST_DELAY       = 2500000,
  parameter int HOLD_FRAMES     = 120
) (
  input  logic                   clkin,
  input  logic                   rst,
  input  logic [NUM_PLAYERS-1:0] z_btn,
  input  logic [NUM_PLAYERS-1:0] c_btn,
  input  logic                   frame_tick,
  output logic [NUM_PLAYERS-1:0] z_press,
  output logic [NUM_PLAYERS-1:0] c_press,
  output logic                   game_rst,
  output logic                   game_run,
  output logic                   start_pulse,
  output logic [1:0]             state,
  output logic [2:0]             paused_by,
  output logic [LED_W-1:0]       leds
);
  localparam int            RW         = cnt_w(RST_DELAY);
  localparam int            FW         = cnt_w(HOLD_FRAMES);
  localparam logic [RW-1:0] RST_LAST   = RW'(RST_DELAY - 1);
  localparam logic [FW-1:0] CHORD_LAST = FW'(HOLD_FRAMES - 1);

  logic [NUM_PLAYERS-1:0] z_lvl, z_rise, c_lvl, c_rise;
  logic [MAX_PLAYERS-1:0] c_rise_ext;
  logic [2:0]             c_low;
  logic                   chord_all, soft_rst;

  ctl_state_t    state_q, state_d;
  logic [RW-1:0] hold_q, hold_d;
  logic [FW-1:0] chord_q, chord_d;
  logic [2:0]    paused_q, paused_d;
  logic          start_q, start_d;

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_btn
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_z (
      .clk(clkin), .rst_n(rst), .btn_raw_i(z_btn[g]),
      .level_o(z_lvl[g]), .rise_o(z_rise[g]), .press_o(z_press[g])
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_c (
      .clk(clkin), .rst_n(rst), .btn_raw_i(c_btn[g]),
      .level_o(c_lvl[g]), .rise_o(c_rise[g]), .press_o(c_press[g])
    );
  end

  always_comb begin
    c_rise_ext                  = '0;
    c_rise_ext[NUM_PLAYERS-1:0] = c_rise;
    c_low                       = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (c_rise[i]) c_low = 3'(i);
    end
  end

  assign chord_all = (&z_lvl) & (&c_lvl);
  assign soft_rst  = ((state_q == PLAY) || (state_q == PAUSE)) && chord_all &&
                     frame_tick && (chord_q == CHORD_LAST);

  // Soft reset is tested first so it beats pause/resume; z presses only matter in IDLE.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    chord_d  = '0;
    paused_d = paused_q;
    start_d  = 1'b0;
    case (state_q)
      HOLD: begin
        if (hold_q == RST_LAST) begin
          state_d = IDLE;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      IDLE: begin
        if (|z_rise) begin
          state_d = PLAY;
          start_d = 1'b1;
        end
      end
      PLAY, PAUSE: begin
        if (soft_rst) begin
          state_d = HOLD;
          hold_d  = '0;
        end else begin
          if (chord_all) begin
            chord_d = (frame_tick && (chord_q != CHORD_LAST)) ? chord_q + 1'b1 : chord_q;
          end
          if ((state_q == PLAY) && (|c_rise)) begin
            state_d  = PAUSE;
            paused_d = c_low;
          end else if ((state_q == PAUSE) && c_rise_ext[paused_q]) begin
            state_d = PLAY;
          end
        end
      end
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      state_q  <= HOLD;
      hold_q   <= '0;
      chord_q  <= '0;
      paused_q <= '0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      chord_q  <= chord_d;
      paused_q <= paused_d;
      start_q  <= start_d;
    end
  end

  assign state       = state_q;
  assign game_rst    = (state_q == HOLD);
  assign game_run    = (state_q == PLAY);
  assign start_pulse = start_q;
  assign paused_by   = paused_q;

  always_comb begin
    leds                                = '0;
    leds[LED_Z_LSB +: NUM_PLAYERS]      = z_lvl;
    leds[LED_STATE_MSB:LED_STATE_LSB]   = state_q;
  end
endmodule

// File: doc/game_control_hub.md
GAME_CONTROL_HUB -- requirements
Module: game_control_hub

Interface
REQ-001 Parameter NUM_PLAYERS, default 2: number of controller channels; legal range 1..8.
REQ-002 Parameter DEBOUNCE_CYCLES, default 250000: consecutive stable cycles required before a debounced level changes.
REQ-003 Parameter RST_DELAY, default 2500000: cycles game_rst stays high after leaving reset or after a soft reset.
REQ-004 Parameter HOLD_FRAMES, default 120: frame ticks of the full-button chord needed to trigger a soft reset.
REQ-005 clkin  input  1  single system clock; all logic on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 z_btn  input  NUM_PLAYERS  raw, asynchronous Z buttons, one bit per player.
REQ-008 c_btn  input  NUM_PLAYERS  raw, asynchronous C buttons, one bit per player.
REQ-009 frame_tick  input  1  one-cycle pulse per video frame, synchronous to clkin.
REQ-010 z_press, c_press  output  NUM_PLAYERS each  one-cycle debounced rising-edge pulses.
REQ-011 game_rst  output  1  reset request to the game logic, active high.
REQ-012 game_run  output  1  high while in PLAY.
REQ-013 start_pulse  output  1  one-cycle pulse on the IDLE->PLAY transition.
REQ-014 state  output  2  current controller state.
REQ-015 paused_by  output  3  index of the player who paused.
REQ-016 leds  output  10  status display.

Function
REQ-017 Each raw button SHALL pass through a 2-flop synchronizer, then a debouncer whose level updates only after DEBOUNCE_CYCLES consecutive cycles of a new synchronized value; any glitch restarts the count.
REQ-018 z_press[i]/c_press[i] SHALL pulse exactly one cycle, DEBOUNCE_CYCLES+2 cycles after the first edge sampling the raw input high, provided it stays high; release produces no pulse.
REQ-019 The FSM SHALL have the states HOLD=0, IDLE=1, PLAY=2 and PAUSE=3.
REQ-020 In HOLD, a counter SHALL run from 0 to RST_DELAY-1 with game_rst=1, then enter IDLE, so game_rst is high for exactly RST_DELAY cycles; presses in HOLD are ignored.
REQ-021 IDLE->PLAY SHALL occur on any z_press, with start_pulse high in the same cycle as the state update.
REQ-022 PLAY->PAUSE SHALL occur on any c_press; paused_by takes the lowest asserting index.
REQ-023 PAUSE->PLAY SHALL occur only on c_press[paused_by]; c_press from other players is ignored.
REQ-024 In PLAY or PAUSE, a chord counter SHALL increment on frame_tick while every debounced z and c level is high, and clear in any cycle where one is low.
REQ-025 When the chord counter reaches HOLD_FRAMES, the FSM SHALL enter HOLD, clear both counters and restart the RST_DELAY count.
REQ-026 On simultaneous events, soft reset SHALL win over pause/resume, and pause/resume SHALL win over a z_press in PLAY or PAUSE.
REQ-027 leds[i] SHALL equal debounced z of player i for i<NUM_PLAYERS, leds[9:8] SHALL equal state, and all other bits SHALL be 0.
REQ-028 The counters SHALL be sized with $clog2 of their limit and SHALL saturate rather than wrap.

Reset
REQ-029 While rst=0, the block SHALL hold: state=HOLD, game_rst=1, all other outputs 0, counters and synchronizers cleared.
REQ-030 Reset assertion mid-operation SHALL take effect immediately without waiting for a clock; release SHALL start a full RST_DELAY count.

Structure
REQ-031 Package game_pkg SHALL hold the ctl_state_t enum (HOLD, IDLE, PLAY, PAUSE) and the LED field positions.
REQ-032 A sub-module button_debounce (synchronizer, debouncer, edge detector; parameter DEBOUNCE_CYCLES) SHALL be instantiated 2*NUM_PLAYERS times.

Verification (NUM_PLAYERS=2, DEBOUNCE_CYCLES=4, RST_DELAY=10, HOLD_FRAMES=3)
REQ-033 Release rst -> game_rst high for exactly 10 cycles, then state=1.
REQ-034 In IDLE, raise z_btn[1] and hold -> z_press[1] and start_pulse high exactly 6 cycles later, state=2; a 3-cycle glitch gives no pulse.
REQ-035 In PLAY, press c_btn of both players together -> state=3, paused_by=0; c_press[1] alone keeps PAUSE; c_press[0] -> state=2.
REQ-036 In PLAY, hold all four buttons for 3 frame_ticks -> state=0, game_rst=1 for 10 cycles; releasing one button after 2 ticks -> no reset.
REQ-037 Assert rst mid-PAUSE -> same cycle, outputs take their reset values asynchronously; leds=10'b0.
